// File: rtl/traffic_pkg.sv
// Shared light encoding and scheduler state codes for the intersection blocks.
// S_WALK exists only when PED_CALL_EN is defined.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10,
        FLASH  = 2'b11
    } light_t;

    typedef enum logic [2:0] {
        S_GREEN   = 3'd0,
        S_YELLOW  = 3'd1,
        S_ALL_RED = 3'd2,
        S_FLASH   = 3'd3
`ifdef PED_CALL_EN
        ,
        S_WALK    = 3'd4
`endif
    } sched_state_t;

endpackage

// File: rtl/phase_rr_picker.sv
// Combinational round-robin search: active_phase+1, +2, ... wrapping,
// with active_phase itself considered last.
module phase_rr_picker #(
    parameter int NUM_PHASES = 4
) (
    input  logic [NUM_PHASES-1:0]         req,
    input  logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic [$clog2(NUM_PHASES)-1:0] grant_idx,
    output logic                          any_req
);
    localparam int IDX_W = $clog2(NUM_PHASES);

    int               idx;
    logic [IDX_W-1:0] sel;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        grant_idx = active_phase;
        idx       = 0;
        sel       = '0;
        for (int k = NUM_PHASES; k >= 1; k--) begin
            idx = (int'(active_phase) + k) % NUM_PHASES;
            sel = IDX_W'(idx);
            if (req[sel]) grant_idx = sel;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Intersection phase scheduler: round-robin green grants with min/max green,
// yellow and all-red clearance, night flash. PED_CALL_EN adds a pedestrian walk interval.
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES   = 4,
    parameter int MIN_GREEN    = 5,
    parameter int MAX_GREEN    = 12,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1,
    parameter int CNT_W        = 8
`ifdef PED_CALL_EN
    ,
    parameter int WALK_TIME    = 6
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          flash,
    input  logic [NUM_PHASES-1:0]         req,
`ifdef PED_CALL_EN
    input  logic                          ped_req,
    output logic                          walk,
`endif
    output logic [2*NUM_PHASES-1:0]       phase_color,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic                          phase_done
);
    localparam int IDX_W = $clog2(NUM_PHASES);
    localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_G = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] YEL_T = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] AR_T  = CNT_W'(ALL_RED_TIME);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
`ifdef PED_CALL_EN
    localparam logic [CNT_W-1:0] WALK_T = CNT_W'(WALK_TIME);
`endif

    sched_state_t          state, state_nxt;
    // Counts up (elapsed green, saturating) in S_GREEN, down to 1 in timed states.
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      active_nxt, grant_idx;
    logic [NUM_PHASES-1:0] others;
    logic                  any_req, other_req, green_exit, expired, done_nxt;
`ifdef PED_CALL_EN
    logic                  ped_pending, walk_start;
`endif

    phase_rr_picker #(.NUM_PHASES(NUM_PHASES)) u_picker (
        .req          (req),
        .active_phase (active_phase),
        .grant_idx    (grant_idx),
        .any_req      (any_req)
    );

    always_comb begin
        others               = req;
        others[active_phase] = 1'b0;
    end

    assign other_req  = |others;
    assign expired    = (cnt <= ONE);
    // Flash never truncates a green below its minimum.
    assign green_exit = (other_req && ((cnt >= MIN_G && !req[active_phase]) || cnt >= MAX_G))
                      || (flash && cnt >= MIN_G);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_ALL_RED;
            cnt          <= AR_T;
            active_phase <= '0;
            phase_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            active_phase <= active_nxt;
            phase_done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        active_nxt = active_phase;
        done_nxt   = 1'b0;
`ifdef PED_CALL_EN
        walk_start = 1'b0;
`endif
        case (state)
            S_GREEN: if (enable) begin
                if (green_exit) begin
                    state_nxt = S_YELLOW;
                    cnt_nxt   = YEL_T;
                    done_nxt  = 1'b1;
                end else if (cnt < MAX_G) begin
                    cnt_nxt = cnt + ONE;
                end
            end
            S_YELLOW: if (enable) begin
                if (expired) begin
                    state_nxt = S_ALL_RED;
                    cnt_nxt   = AR_T;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            // At expiry the decision is re-made every enabled cycle until something is pending.
            S_ALL_RED: if (enable) begin
                if (!expired) begin
                    cnt_nxt = cnt - ONE;
                end else if (flash) begin
                    state_nxt = S_FLASH;
`ifdef PED_CALL_EN
                end else if (ped_pending) begin
                    state_nxt  = S_WALK;
                    cnt_nxt    = WALK_T;
                    walk_start = 1'b1;
`endif
                end else if (any_req) begin
                    state_nxt  = S_GREEN;
                    cnt_nxt    = ONE;
                    active_nxt = grant_idx;
                end
            end
            S_FLASH: if (enable && !flash) begin
                state_nxt = S_ALL_RED;
                cnt_nxt   = AR_T;
            end
`ifdef PED_CALL_EN
            S_WALK: if (enable) begin
                if (expired) begin
                    state_nxt = S_ALL_RED;
                    cnt_nxt   = AR_T;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
`endif
            default: begin
                state_nxt = S_ALL_RED;
                cnt_nxt   = AR_T;
            end
        endcase
    end

    always_comb begin
        phase_color = {NUM_PHASES{RED}};
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (state == S_FLASH) begin
                phase_color[2*i +: 2] = FLASH;
            end else if (IDX_W'(i) == active_phase) begin
                if (state == S_GREEN)       phase_color[2*i +: 2] = GREEN;
                else if (state == S_YELLOW) phase_color[2*i +: 2] = YELLOW;
            end
        end
    end

`ifdef PED_CALL_EN
    assign walk = (state == S_WALK);

    // Calls arriving while enable is low are still remembered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           ped_pending <= 1'b0;
        else if (walk_start) ped_pending <= 1'b0;
        else if (ped_req)    ped_pending <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: rule-level model compared every cycle,
// plus directed scenarios with literal expectations. PED_CALL_EN enables the walk scenario.
module tb_intersection_phase_scheduler;
    localparam int NP = 4, MIN_G = 5, MAX_G = 12, YEL = 2, AR = 1, WALK_N = 6;
    localparam int MG = 0, MY = 1, MR = 2, MF = 3, MW = 4;
    localparam logic [2*NP-1:0] ALL_RED_C = 8'hAA;

    logic            clk = 1'b0;
    logic            reset, enable, flash, ped_req, walk;
    logic [NP-1:0]   req;
    logic [2*NP-1:0] phase_color;
    logic [1:0]      active_phase;
    logic            phase_done;

    int n_checks = 0, n_fail = 0;
    int m_mode = MR, m_act = 0, m_el = 0, m_cur;
    bit m_done = 0, m_ped = 0, m_others, m_wstart, chk_on = 0;
    int n, g, prev, live;
    int exp_order [4] = '{2, 3, 0, 1};

    always #5 clk = ~clk;

    intersection_phase_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable), .flash(flash), .req(req),
`ifdef PED_CALL_EN
        .ped_req(ped_req), .walk(walk),
`endif
        .phase_color(phase_color), .active_phase(active_phase), .phase_done(phase_done)
    );
`ifndef PED_CALL_EN
    assign walk = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each interval tracks enabled cycles elapsed; durations come straight from the rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = MR; m_act = 0; m_el = 0; m_done = 0; m_ped = 0;
        end else begin
            m_done = 0; m_wstart = 0;
            if (enable) begin
                m_cur = m_el + 1;
                case (m_mode)
                    MG: begin
                        m_others = 0;
                        for (int i = 0; i < NP; i++) if (i != m_act && req[i]) m_others = 1;
                        if ((m_others && ((m_cur >= MIN_G && !req[m_act]) || m_cur >= MAX_G))
                            || (flash && m_cur >= MIN_G)) begin
                            m_mode = MY; m_el = 0; m_done = 1;
                        end else m_el = m_cur;
                    end
                    MY: if (m_cur >= YEL) begin m_mode = MR; m_el = 0; end else m_el = m_cur;
                    MR: begin
                        if (m_cur < AR) m_el = m_cur;
                        else if (flash) begin m_mode = MF; m_el = 0; end
                        else if (m_ped) begin m_mode = MW; m_el = 0; m_ped = 0; m_wstart = 1; end
                        else if (req != '0) begin
                            for (int i = 1; i <= NP; i++)
                                if (req[(m_act + i) % NP]) begin m_act = (m_act + i) % NP; break; end
                            m_mode = MG; m_el = 0;
                        end
                    end
                    MF: if (!flash) begin m_mode = MR; m_el = 0; end
                    MW: if (m_cur >= WALK_N) begin m_mode = MR; m_el = 0; end else m_el = m_cur;
                    default: m_mode = MR;
                endcase
            end
`ifdef PED_CALL_EN
            if (ped_req && !m_wstart) m_ped = 1;
`endif
        end
    end

    function automatic logic [2*NP-1:0] exp_color(input int mode, input int act);
        logic [2*NP-1:0] c;
        for (int i = 0; i < NP; i++) begin
            c[2*i +: 2] = 2'b10;
            if (mode == MF)                   c[2*i +: 2] = 2'b11;
            else if (i == act && mode == MG)  c[2*i +: 2] = 2'b00;
            else if (i == act && mode == MY)  c[2*i +: 2] = 2'b01;
        end
        return c;
    endfunction

    always @(negedge clk) if (chk_on) begin
        live = 0;
        for (int i = 0; i < NP; i++) if (phase_color[2*i +: 2] == 2'b00 || phase_color[2*i +: 2] == 2'b01) live++;
        chk("model_color", phase_color, exp_color(m_mode, m_act));
        chk("model_active", active_phase, m_act);
        chk("model_done", phase_done, m_done);
        chk("safety_single_live", live > 1, 0);
`ifdef PED_CALL_EN
        chk("model_walk", walk, m_mode == MW);
`endif
    end

    function automatic logic [1:0] col(input int ph);
        return phase_color[2*ph +: 2];
    endfunction

    function automatic int green_phase();
        for (int i = 0; i < NP; i++) if (phase_color[2*i +: 2] == 2'b00) return i;
        return -1;
    endfunction

    task automatic wait_code(input int ph, input logic [1:0] code, input string name);
        int k = 0;
        while (col(ph) !== code && k < 200) begin @(negedge clk); k++; end
        if (col(ph) !== code) chk({"timeout_", name}, col(ph), code);
    endtask

    task automatic count_code(input int ph, input logic [1:0] code, output int cnt);
        cnt = 0;
        while (col(ph) === code && cnt < 200) begin cnt++; @(negedge clk); end
    endtask

    task automatic count_red(output int cnt);
        cnt = 0;
        while (phase_color === ALL_RED_C && cnt < 200) begin cnt++; @(negedge clk); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; flash = 1'b0; req = 4'b0100; ped_req = 1'b0;
        @(negedge clk); chk_on = 1;
        @(negedge clk);
        chk("reset_color", phase_color, 8'hAA);
        chk("reset_active", active_phase, 0);
        chk("reset_done", phase_done, 0);
        #2 reset = 1'b0;

        // One all-red cycle, then phase 2 rests green.
        @(negedge clk);
        chk("first_green_color", phase_color, 8'h8A);
        chk("first_green_active", active_phase, 2);
        repeat (20) @(negedge clk);
        chk("rest_green_color", phase_color, 8'h8A);

        // Phase 0 held with phase 1 waiting: max green.
        req = 4'b0011;
        wait_code(0, 2'b00, "green0");
        count_code(0, 2'b00, n);
        chk("max_green_len", n, 12);
        chk("max_green_done", phase_done, 1);
        count_code(0, 2'b01, n);
        chk("yellow_len", n, 2);
        count_red(n);
        chk("all_red_len", n, 1);
        chk("after_max_active", active_phase, 1);
        chk("after_max_color", phase_color, 8'hA2);

        // Phase 0 request drops at cycle 2 with phase 3 waiting: min green.
        req = 4'b0001;
        wait_code(0, 2'b00, "green0_min");
        @(negedge clk);
        req = 4'b1000;
        count_code(0, 2'b00, n);
        chk("min_green_len", n + 1, 5);
        wait_code(3, 2'b00, "green3");
        chk("min_next_active", active_phase, 3);
        chk("min_next_color", phase_color, 8'h2A);

        // All requesting from phase 1: order 2, 3, 0, 1.
        req = 4'b0010;
        wait_code(1, 2'b00, "green1");
        req = 4'b1111;
        prev = 1;
        for (int k = 0; k < 4; k++) begin
            n = 0; g = green_phase();
            while (n < 200 && !(g >= 0 && g != prev)) begin @(negedge clk); n++; g = green_phase(); end
            chk($sformatf("rr_order_%0d", k), g, exp_order[k]);
            prev = g;
        end

        // Flash raised in phase 1 green.
        flash = 1'b1;
        count_code(1, 2'b00, n);
        chk("flash_green_len", n, 5);
        chk("flash_green_done", phase_done, 1);
        count_code(1, 2'b01, n);
        chk("flash_yellow_len", n, 2);
        count_red(n);
        chk("flash_all_red_len", n, 1);
        chk("flash_color", phase_color, 8'hFF);
        repeat (3) @(negedge clk);
        chk("flash_hold_color", phase_color, 8'hFF);
        flash = 1'b0;
        @(negedge clk);
        count_red(n);
        chk("unflash_all_red_len", n, 1);
        chk("unflash_active", active_phase, 2);
        chk("unflash_color", phase_color, 8'h8A);

        // Freeze three cycles in phase 2 yellow.
        wait_code(2, 2'b01, "yellow2");
        chk("freeze_entry_done", phase_done, 1);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("freeze_color_%0d", k), phase_color, 8'h9A);
            chk($sformatf("freeze_done_%0d", k), phase_done, 0);
        end
        enable = 1'b1;
        count_code(2, 2'b01, n);
        chk("freeze_yellow_tail", n, 2);
        count_red(n);
        chk("freeze_all_red_len", n, 1);
        chk("freeze_next_color", phase_color, 8'h2A);

`ifdef PED_CALL_EN
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        n = 0;
        while (walk !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("walk_seen", walk, 1);
        chk("walk_color", phase_color, 8'hAA);
        chk("walk_active", active_phase, 3);
        n = 0;
        while (walk === 1'b1 && n < 200) begin n++; @(negedge clk); end
        chk("walk_len", n, 6);
        count_red(n);
        chk("walk_all_red_len", n, 1);
        chk("walk_next_active", active_phase, 0);
`endif

        // Reset in the middle of a green.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_color", phase_color, 8'hAA);
        chk("midreset_active", active_phase, 0);
        chk("midreset_done", phase_done, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        wait_code(1, 2'b00, "post_reset_green1");
        chk("post_reset_active", active_phase, 1);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Sequences the approach signal heads of one intersection; one conflicting phase is green at a time.
- Grants green to vehicle-detector requests in round-robin order, enforces min/max green, yellow and all-red clearance, and provides a night flash mode.
- Sits above the per-head light drivers and uses the team's 2-bit light encoding: 00 green, 01 yellow, 10 red, 11 flashing yellow.

Parameters:
- NUM_PHASES, 4: number of conflicting phases, 2..8.
- MIN_GREEN, 5: minimum green duration in enabled cycles, ≥1.
- MAX_GREEN, 12: maximum green while another phase waits, ≥MIN_GREEN.
- YELLOW_TIME, 2: yellow duration in enabled cycles, ≥1.
- ALL_RED_TIME, 1: all-red clearance duration in enabled cycles, ≥1.
- CNT_W, 8: timer width; must hold MAX_GREEN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  advance tick; when low, state and timers freeze.
- flash  in  1  request flash mode.
- req  in  NUM_PHASES  level detector call per phase.
- phase_color  out  2*NUM_PHASES  light code; phase i occupies bits [2i+1:2i].
- active_phase  out  $clog2(NUM_PHASES)  last or currently granted phase.
- phase_done  out  1  one-cycle pulse when a green ends (green→yellow).

Behaviour:
- States:
  - S_GREEN: active phase = 00, others 10.
  - S_YELLOW: active phase = 01, others 10.
  - S_ALL_RED: all phases 10.
  - S_FLASH: all phases 11.
- Outputs are Moore, decoded from registered state.
- Reset:
  - state S_ALL_RED, timer loaded for ALL_RED_TIME.
  - active_phase 0, phase_done 0, all phase_color 10.
- Timing: every timed state lasts exactly its N enabled cycles. The timer is reloaded on entry and decrements only when enable=1. With enable=0, nothing changes and phase_done stays 0.
- S_ALL_RED expiry, evaluated on the enabled cycle where the timer is at its last count:
  - If flash=1 → S_FLASH.
  - Else if any req → S_GREEN on the round-robin winner, then active_phase updates.
    - Search order: active_phase+1, +2, … wrapping; active_phase itself is last.
  - Else hold S_ALL_RED at expiry, re-evaluating every enabled cycle.
- S_GREEN:
  - Elapsed count g saturates at MAX_GREEN.
  - Exit to S_YELLOW when another phase's req=1 and either:
    - g ≥ MIN_GREEN and req[active]=0, or
    - g = MAX_GREEN.
  - With no other request, rest in green indefinitely.
  - phase_done pulses on the exit cycle.
  - flash=1 during green does not cut green short; it forces exit at MIN_GREEN via yellow.
- S_YELLOW: after YELLOW_TIME → S_ALL_RED.
- S_FLASH: stay while flash=1. When flash=0 → S_ALL_RED, reload ALL_RED_TIME. active_phase is unchanged.
- Safety:
  - Never two phases non-red.
  - Green is always followed by yellow and then all-red.
  - S_FLASH is entered only from S_ALL_RED.
- Illegal or unreachable state → S_ALL_RED.
- Reset mid-green: immediately all red, state per reset values.

Optional Feature:
- Macro: PED_CALL_EN.
- When defined:
  - Adds parameter WALK_TIME (default 6), input ped_req (1), output walk (1).
  - ped_req is latched into a pending flag. The flag clears when the walk interval starts.
  - At S_ALL_RED expiry with the flag set and flash=0, enter S_WALK: all vehicles 10, walk=1, for WALK_TIME enabled cycles, then → S_ALL_RED.
  - Pedestrian calls take priority over vehicle requests. active_phase is unchanged.
- When undefined: no such ports or state, and walk logic is absent.

Decomposition:
- Package traffic_pkg:
  - light_t enum: GREEN 2'b00, YELLOW 2'b01, RED 2'b10, FLASH 2'b11.
  - sched_state_t enum: S_GREEN, S_YELLOW, S_ALL_RED, S_FLASH, S_WALK.
- Sub-module phase_rr_picker: combinational round-robin search.
  - Inputs: req, active_phase.
  - Outputs: grant_idx, any_req.
- Top level holds the FSM, timers and output decode.

Test Plan:
- Reset, enable=1, req=4'b0100: all red for 1 cycle → phase 2 green; it rests green indefinitely with no other requests.
- Phase 0 green, req[0] held, req[1] asserted: green ends at exactly 12 cycles with a phase_done pulse → yellow 2 cycles → all-red 1 cycle → phase 1 green.
- Phase 0 green, req[0] drops at cycle 2, req[3]=1: green ends at exactly 5 cycles (MIN_GREEN) → phase 3 green after clearance.
- req=4'b1111 continuously from phase 1: grant order is 2, 3, 0, 1. Assert no two phases are ever non-red.
- flash raised mid-green: yellow, then all-red, then all codes 11. flash dropped: all-red for 1 cycle, then the next round-robin phase.
- enable toggled 0 for 3 cycles mid-yellow: outputs are frozen and yellow spans 2 enabled cycles. With PED_CALL_EN, a ped_req pulse → walk=1 for 6 cycles after the next all-red.
